ex_compute_unit: RTL and testbench



---
 rtl/exu_pkg.sv | 55 +++++
 rtl/exu_mul.sv | 111 +++++++++++
 rtl/ex_compute_unit.sv | 85 ++++++++
 tb/tb_ex_compute_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// Shared types for the execute-stage compute unit.
// Operation encodings, multiplier states and the product helper.
package exu_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [63:0] u64_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_NOR   = 4'd6,
        ALU_XOR   = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_PASSB = 4'd11
    } alu_op_t;

    typedef enum logic [2:0] {
        BRU_EQ     = 3'd0,
        BRU_NE     = 3'd1,
        BRU_LT     = 3'd2,
        BRU_GE     = 3'd3,
        BRU_LTU    = 3'd4,
        BRU_GEU    = 3'd5,
        BRU_ALWAYS = 3'd6,
        BRU_NEVER  = 3'd7
    } bru_op_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // Counter holds MUL_STAGES-1, so 3 bits cover the legal 1..8 range.
    localparam int CNT_W = 3;

    // 33-bit extended operands keep one multiplier for both signednesses.
    function automatic u64_t mul64(input u32_t a, input u32_t b,
                                   input logic s);
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [65:0] p;
        ea = {s & a[31], a};
        eb = {s & b[31], b};
        p  = ea * eb;
        return p[63:0];
    endfunction

endpackage

// File: rtl/exu_mul.sv
// Multi-cycle 32x32->64 multiplier with start/done handshake and flush.
// Define EXU_MUL_SINGLE_CYCLE_EN for a combinational, zero-stall variant.
module exu_mul
    import exu_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mul_flush,
    input  logic        mul_en,
    input  logic        mul_signed,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    output logic [63:0] mul_out,
    output logic        mul_done
);

`ifdef EXU_MUL_SINGLE_CYCLE_EN

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    // Product follows the live operands; done answers in the request cycle.
    always_comb begin
        mul_out  = mul64(mul_a, mul_b, mul_signed);
        mul_done = mul_en & ~mul_flush;
    end

`else

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    u32_t             a_q, a_d;
    u32_t             b_q, b_d;
    logic             s_q, s_d;
    u64_t             out_q, out_d;

    // Next-state logic; the product is latched on the way into DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        out_d   = out_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (mul_en) begin
                    a_d = mul_a;
                    b_d = mul_b;
                    s_d = mul_signed;
                    if (MUL_STAGES == 1) begin
                        state_d = MUL_DONE;
                        cnt_d   = '0;
                        out_d   = mul64(mul_a, mul_b, mul_signed);
                    end else begin
                        state_d = MUL_BUSY;
                        cnt_d   = CNT_W'(MUL_STAGES - 1);
                    end
                end
            end
            MUL_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = MUL_DONE;
                    out_d   = mul64(a_q, b_q, s_q);
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
        if (mul_flush) begin
            state_d = MUL_IDLE;
            cnt_d   = '0;
            out_d   = out_q;
        end
    end

    // State, captured operands and held product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            out_q   <= out_d;
        end
    end

    // A flush in the DONE cycle suppresses the pulse immediately.
    always_comb begin
        mul_out  = out_q;
        mul_done = (state_q == MUL_DONE) & ~mul_flush;
    end

`endif

endmodule

// File: rtl/ex_compute_unit.sv
// Execute-stage arithmetic: ALU, branch resolver and multiplier.
// EXU_MUL_SINGLE_CYCLE_EN selects the combinational multiplier.
module ex_compute_unit
    import exu_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  alu_op,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [31:0] alu_out,
    input  logic [2:0]  bru_op,
    input  logic [31:0] bru_a,
    input  logic [31:0] bru_b,
    output logic        br_taken,
    input  logic        mul_flush,
    input  logic        mul_en,
    input  logic        mul_signed,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    output logic [63:0] mul_out,
    output logic        mul_done
);

    alu_op_t    aop;
    bru_op_t    bop;
    logic [4:0] sh;

    assign aop = alu_op_t'(alu_op);
    assign bop = bru_op_t'(bru_op);
    assign sh  = alu_b[4:0];

    // ALU: 32-bit wrap-around arithmetic, unused codes give zero.
    always_comb begin
        alu_out = '0;
        case (aop)
            ALU_ADD:   alu_out = alu_a + alu_b;
            ALU_SUB:   alu_out = alu_a - alu_b;
            ALU_SLT:   alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:  alu_out = {31'd0, alu_a < alu_b};
            ALU_AND:   alu_out = alu_a & alu_b;
            ALU_OR:    alu_out = alu_a | alu_b;
            ALU_NOR:   alu_out = ~(alu_a | alu_b);
            ALU_XOR:   alu_out = alu_a ^ alu_b;
            ALU_SLL:   alu_out = alu_a << sh;
            ALU_SRL:   alu_out = alu_a >> sh;
            ALU_SRA:   alu_out = u32_t'($signed(alu_a) >>> sh);
            ALU_PASSB: alu_out = alu_b;
            default:   alu_out = '0;
        endcase
    end

    // Branch condition on rj/rkd.
    always_comb begin
        br_taken = 1'b0;
        case (bop)
            BRU_EQ:     br_taken = (bru_a == bru_b);
            BRU_NE:     br_taken = (bru_a != bru_b);
            BRU_LT:     br_taken = ($signed(bru_a) <  $signed(bru_b));
            BRU_GE:     br_taken = ($signed(bru_a) >= $signed(bru_b));
            BRU_LTU:    br_taken = (bru_a <  bru_b);
            BRU_GEU:    br_taken = (bru_a >= bru_b);
            BRU_ALWAYS: br_taken = 1'b1;
            BRU_NEVER:  br_taken = 1'b0;
            default:    br_taken = 1'b0;
        endcase
    end

    exu_mul #(
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_flush  (mul_flush),
        .mul_en     (mul_en),
        .mul_signed (mul_signed),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_out    (mul_out),
        .mul_done   (mul_done)
    );

endmodule

// File: tb/tb_ex_compute_unit.sv
// Self-checking bench for ex_compute_unit (default multi-cycle build).
// Vector table plus random traffic against an arithmetic reference.
module tb_ex_compute_unit;

    localparam int MS = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic [2:0]  bru_op;
    logic [31:0] bru_a;
    logic [31:0] bru_b;
    logic        br_taken;
    logic        mul_flush;
    logic        mul_en;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_out;
    logic        mul_done;

    int vectors;
    int miscompares;

    ex_compute_unit #(
        .MUL_STAGES (MS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .bru_op     (bru_op),
        .bru_a      (bru_a),
        .bru_b      (bru_b),
        .br_taken   (br_taken),
        .mul_flush  (mul_flush),
        .mul_en     (mul_en),
        .mul_signed (mul_signed),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_out    (mul_out),
        .mul_done   (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_bru;
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    function automatic logic [31:0] ref_alu(input int op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned p = longint'(1) << (b % 32);
        longint r;
        case (op)
            0:  return 32'((ua + ub) % TWO32);
            1:  return 32'((ua + TWO32 - ub) % TWO32);
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (ua < ub) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return a | b;
            6:  return ~(a | b);
            7:  return a ^ b;
            8:  return 32'((ua * p) % TWO32);
            9:  return 32'(ua / p);
            10: begin
                if (sa >= 0) r = sa / longint'(p);
                else r = -((-sa + longint'(p) - 1) / longint'(p));
                return 32'(r);
            end
            11: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_bru(input int op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = a;
        longint unsigned ub = b;
        case (op)
            0: return ua == ub;
            1: return ua != ub;
            2: return sa < sb;
            3: return sa >= sb;
            4: return ua < ub;
            5: return ua >= ub;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input bit s);
        longint sp;
        longint unsigned up;
        longint unsigned ua = a;
        longint unsigned ub = b;
        if (s) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return 64'(sp);
        end
        up = ua * ub;
        return up;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input bit s, input bit keep, input string nm);
        logic [63:0] exp;
        int lat;
        exp = ref_mul(a, b, s);
        lat = -1;
        mul_a = a;
        mul_b = b;
        mul_signed = s;
        mul_en = 1'b1;
        for (int k = 0; k <= MS + 4; k++) begin
            @(negedge clk);
            if (mul_done) begin
                lat = k;
                break;
            end
            step();
            mul_a = $urandom;
            mul_b = $urandom;
            mul_signed = 1'($urandom_range(0, 1));
        end
        chk({nm, " latency"}, 64'(lat), 64'(MS));
        chk({nm, " product"}, mul_out, exp);
        step();
        mul_en = keep;
    endtask

    vec_t tbl[$];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        alu_op = '0;
        alu_a = '0;
        alu_b = '0;
        bru_op = '0;
        bru_a = '0;
        bru_b = '0;
        mul_flush = 1'b0;
        mul_en = 1'b0;
        mul_signed = 1'b0;
        mul_a = '0;
        mul_b = '0;

        #3;
        chk("reset mul_done", 64'(mul_done), 64'd0);
        chk("reset mul_out", mul_out, 64'd0);
        step();
        step();
        rst_n = 1'b1;

        tbl.push_back('{"ADD",   0, 0,  32'h80000000, 32'h1, 32'h80000001});
        tbl.push_back('{"SUB",   0, 1,  32'h80000000, 32'h1, 32'h7FFFFFFF});
        tbl.push_back('{"SLT",   0, 2,  32'h80000000, 32'h1, 32'h1});
        tbl.push_back('{"SLTU",  0, 3,  32'h80000000, 32'h1, 32'h0});
        tbl.push_back('{"SRA",   0, 10, 32'h80000000, 32'h21, 32'hC0000000});
        tbl.push_back('{"SRL",   0, 9,  32'h80000000, 32'h1, 32'h40000000});
        tbl.push_back('{"NOR",   0, 6,  32'h80000000, 32'h1, 32'h7FFFFFFE});
        tbl.push_back('{"PASSB", 0, 11, 32'h80000000, 32'h1, 32'h1});
        tbl.push_back('{"AND",   0, 4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
        tbl.push_back('{"OR",    0, 5,  32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0});
        tbl.push_back('{"XOR",   0, 7,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00});
        tbl.push_back('{"SLL",   0, 8,  32'h00000003, 32'hFFFFFFFF, 32'h80000000});
        tbl.push_back('{"OP12",  0, 12, 32'h12345678, 32'h1, 32'h0});
        tbl.push_back('{"OP15",  0, 15, 32'h12345678, 32'h1, 32'h0});
        tbl.push_back('{"LT",    1, 2,  32'hFFFFFFFF, 32'h1, 32'h1});
        tbl.push_back('{"LTU",   1, 4,  32'hFFFFFFFF, 32'h1, 32'h0});
        tbl.push_back('{"GE",    1, 3,  32'hFFFFFFFF, 32'h1, 32'h0});
        tbl.push_back('{"GEU",   1, 5,  32'hFFFFFFFF, 32'h1, 32'h1});
        tbl.push_back('{"EQ",    1, 0,  32'hFFFFFFFF, 32'h1, 32'h0});
        tbl.push_back('{"NE",    1, 1,  32'hFFFFFFFF, 32'h1, 32'h1});
        tbl.push_back('{"ALWAYS", 1, 6, 32'hFFFFFFFF, 32'h1, 32'h1});
        tbl.push_back('{"NEVER", 1, 7,  32'hFFFFFFFF, 32'h1, 32'h0});

        foreach (tbl[i]) begin
            if (tbl[i].is_bru) begin
                bru_op = 3'(tbl[i].op);
                bru_a = tbl[i].a;
                bru_b = tbl[i].b;
                @(negedge clk);
                chk({"bru ", tbl[i].name}, 64'(br_taken), 64'(tbl[i].exp));
            end else begin
                alu_op = 4'(tbl[i].op);
                alu_a = tbl[i].a;
                alu_b = tbl[i].b;
                @(negedge clk);
                chk({"alu ", tbl[i].name}, 64'(alu_out), 64'(tbl[i].exp));
            end
            step();
        end

        for (int i = 0; i < 200; i++) begin
            int op;
            int bop;
            op = int'($urandom_range(0, 15));
            bop = int'($urandom_range(0, 7));
            alu_op = 4'(op);
            alu_a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            alu_b = $urandom;
            bru_op = 3'(bop);
            bru_a = $urandom;
            bru_b = ($urandom_range(0, 3) == 0) ? bru_a : $urandom;
            @(negedge clk);
            chk($sformatf("alu rnd op%0d", op), 64'(alu_out),
                64'(ref_alu(op, alu_a, alu_b)));
            chk($sformatf("bru rnd op%0d", bop), 64'(br_taken),
                64'(ref_bru(bop, bru_a, bru_b)));
            step();
        end

        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "umul max");
        @(negedge clk);
        chk("umul done low after", 64'(mul_done), 64'd0);
        chk("umul out held", mul_out, 64'hFFFFFFFE00000001);
        step();

        run_mul(32'hFFFFFFFE, 32'd3, 1'b1, 1'b1, "smul -2*3");
        run_mul(32'd7, 32'd6, 1'b1, 1'b0, "smul 7*6 b2b");
        chk("b2b value 42", mul_out, 64'd42);

        mul_a = 32'h1234;
        mul_b = 32'h5678;
        mul_signed = 1'b0;
        mul_en = 1'b1;
        @(negedge clk);
        chk("flush c0 done", 64'(mul_done), 64'd0);
        step();
        mul_flush = 1'b1;
        @(negedge clk);
        chk("flush c1 done", 64'(mul_done), 64'd0);
        step();
        mul_flush = 1'b0;
        mul_en = 1'b0;
        @(negedge clk);
        chk("flush c2 done", 64'(mul_done), 64'd0);
        step();
        run_mul(32'h0000ABCD, 32'h00010001, 1'b0, 1'b0, "after flush");

        mul_a = 32'd11;
        mul_b = 32'd13;
        mul_signed = 1'b0;
        mul_en = 1'b1;
        for (int k = 0; k < MS; k++) begin
            @(negedge clk);
            chk("pre-done no pulse", 64'(mul_done), 64'd0);
            step();
        end
        mul_flush = 1'b1;
        @(negedge clk);
        chk("flush in DONE", 64'(mul_done), 64'd0);
        step();
        mul_flush = 1'b0;
        mul_en = 1'b0;
        @(negedge clk);
        chk("after DONE flush", 64'(mul_done), 64'd0);
        step();

        run_mul(32'd100, 32'd200, 1'b0, 1'b0, "pre-reset");
        mul_a = 32'd5;
        mul_b = 32'd9;
        mul_en = 1'b1;
        step();
        @(negedge clk);
        chk("busy no done", 64'(mul_done), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst done", 64'(mul_done), 64'd0);
        chk("async rst out", mul_out, 64'd0);
        mul_en = 1'b0;
        step();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst no done", 64'(mul_done), 64'd0);
        step();
        run_mul(32'hDEADBEEF, 32'h00000010, 1'b0, 1'b0, "post-rst");

        for (int i = 0; i < 40; i++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            run_mul($urandom, $urandom, 1'($urandom_range(0, 1)), keep,
                    $sformatf("rnd mul %0d", i));
            if (!keep) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    @(negedge clk);
                    chk("idle no done", 64'(mul_done), 64'd0);
                    step();
                end
            end
        end
        mul_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
